// File: rtl/riscv_pkg.sv
// Shared types and constants for the pipeline's trap/interrupt logic.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SAFE = 2'd1,
        TRAP      = 2'd2,
        HANDLER   = 2'd3
    } intr_state_t;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;

    // mip bit positions as exposed on mip_o
    localparam int MIP_MTIP = 0;
    localparam int MIP_MEIP = 1;

endpackage

// File: rtl/intr_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line, followed by a
// single-cycle rising-edge pulse so a held-high level counts as one event.
module intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q[0] <= 1'b0;
        end else begin
            sync_q[0] <= async_i;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_q[gi] <= 1'b0;
                end else begin
                    sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_controller.sv
// Machine timer/external interrupt sequencer: latches pending bits, waits for a
// safe pipeline point, then holds a trap request until csr_regs acknowledges it.
module intr_controller
    import riscv_pkg::*;
#(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          t_intr_i,
    input  logic          e_intr_i,
    input  logic          mstatus_mie_i,
    input  logic          mie_mtie_i,
    input  logic          mie_meie_i,
    input  logic          stall_fd_i,
    input  logic          br_flush_i,
    input  logic [DW-1:0] pc_d_i,
    input  logic          trap_ack_i,
    input  logic          is_mret_i,
    output logic          trap_req_o,
    output logic          flush_o,
    output logic [DW-1:0] trap_cause_o,
    output logic [DW-1:0] trap_epc_o,
    output logic [1:0]    mip_o
);

    localparam logic [DW-1:0] CAUSE_MEI = DW'(MCAUSE_MEI);
    localparam logic [DW-1:0] CAUSE_MTI = DW'(MCAUSE_MTI);

    intr_state_t   state_q, state_d;
    logic [1:0]    pend_q, pend_d;
    logic [DW-1:0] cause_q, cause_d;
    logic [DW-1:0] epc_q, epc_d;
    logic          taken_ext_q, taken_ext_d;

    logic t_edge, e_edge;
    logic ext_en, tmr_en, take, safe, ack_in_trap;

    intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_t (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .async_i(t_intr_i),
        .pulse_o(t_edge)
    );

    intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .async_i(e_intr_i),
        .pulse_o(e_edge)
    );

    assign ext_en      = pend_q[MIP_MEIP] & mie_meie_i;
    assign tmr_en      = pend_q[MIP_MTIP] & mie_mtie_i;
    assign take        = mstatus_mie_i & (ext_en | tmr_en);
    assign safe        = ~stall_fd_i & ~br_flush_i;
    assign ack_in_trap = (state_q == TRAP) & trap_ack_i;

    // A new edge on the same cycle as the acknowledge keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        if (ack_in_trap) begin
            if (taken_ext_q) pend_d[MIP_MEIP] = 1'b0;
            else             pend_d[MIP_MTIP] = 1'b0;
        end
        if (e_edge) pend_d[MIP_MEIP] = 1'b1;
        if (t_edge) pend_d[MIP_MTIP] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        taken_ext_d = taken_ext_q;
        unique case (state_q)
            IDLE: begin
                if (take && safe)  state_d = TRAP;
                else if (take)     state_d = WAIT_SAFE;
            end
            WAIT_SAFE: begin
                if (!take)         state_d = IDLE;
                else if (safe)     state_d = TRAP;
            end
            TRAP: begin
                if (trap_ack_i)    state_d = HANDLER;
            end
            HANDLER: begin
                if (is_mret_i)     state_d = IDLE;
            end
            default:               state_d = IDLE;
        endcase
        // Cause and EPC are captured only on the entry edge and then frozen.
        if (state_q != TRAP && state_d == TRAP) begin
            taken_ext_d = ext_en;
            cause_d     = ext_en ? CAUSE_MEI : CAUSE_MTI;
            epc_d       = pc_d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            cause_q     <= '0;
            epc_q       <= '0;
            taken_ext_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            taken_ext_q <= taken_ext_d;
        end
    end

    assign trap_req_o   = (state_q == TRAP);
    assign flush_o      = (state_q == TRAP);
    assign trap_cause_o = cause_q;
    assign trap_epc_o   = epc_q;
    assign mip_o        = pend_q;

endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller: latency, priority, safe-point wait,
// enable gating, nesting block and asynchronous reset.
module tb_intr_controller;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        t_intr_i, e_intr_i;
    logic        mstatus_mie_i, mie_mtie_i, mie_meie_i;
    logic        stall_fd_i, br_flush_i;
    logic [31:0] pc_d_i;
    logic        trap_ack_i, is_mret_i;
    logic        trap_req_o, flush_o;
    logic [31:0] trap_cause_o, trap_epc_o;
    logic [1:0]  mip_o;

    int total = 0;
    int bad   = 0;

    intr_controller #(.DW(32), .SYNC_STAGES(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .t_intr_i     (t_intr_i),
        .e_intr_i     (e_intr_i),
        .mstatus_mie_i(mstatus_mie_i),
        .mie_mtie_i   (mie_mtie_i),
        .mie_meie_i   (mie_meie_i),
        .stall_fd_i   (stall_fd_i),
        .br_flush_i   (br_flush_i),
        .pc_d_i       (pc_d_i),
        .trap_ack_i   (trap_ack_i),
        .is_mret_i    (is_mret_i),
        .trap_req_o   (trap_req_o),
        .flush_o      (flush_o),
        .trap_cause_o (trap_cause_o),
        .trap_epc_o   (trap_epc_o),
        .mip_o        (mip_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic ack_cycle();
        trap_ack_i = 1'b1;
        step(1);
        trap_ack_i = 1'b0;
    endtask

    task automatic mret_cycle();
        is_mret_i = 1'b1;
        step(1);
        is_mret_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; t_intr_i = 0; e_intr_i = 0;
        mstatus_mie_i = 0; mie_mtie_i = 0; mie_meie_i = 0;
        stall_fd_i = 0; br_flush_i = 0; pc_d_i = 32'h100;
        trap_ack_i = 0; is_mret_i = 0;
        step(2);
        check("rst_req",   {31'd0, trap_req_o}, 32'd0);
        check("rst_flush", {31'd0, flush_o},    32'd0);
        check("rst_mip",   {30'd0, mip_o},      32'd0);
        check("rst_cause", trap_cause_o,        32'd0);
        check("rst_epc",   trap_epc_o,          32'd0);
        rst_ni = 1'b1;
        step(1);

        // 1: timer latency, cause, epc, clear on ack
        mstatus_mie_i = 1; mie_mtie_i = 1; mie_meie_i = 1;
        t_intr_i = 1;
        step(2);
        check("t1_mip_early", {30'd0, mip_o}, 32'd0);
        step(1);
        check("t1_mip",       {30'd0, mip_o}, 32'd1);
        check("t1_req_early", {31'd0, trap_req_o}, 32'd0);
        pc_d_i = 32'h200;
        step(1);
        check("t1_req",   {31'd0, trap_req_o}, 32'd1);
        check("t1_flush", {31'd0, flush_o},    32'd1);
        check("t1_cause", trap_cause_o, 32'h8000_0007);
        check("t1_epc",   trap_epc_o,   32'h200);
        pc_d_i = 32'h300;
        step(1);
        check("t1_held",     {31'd0, trap_req_o}, 32'd1);
        check("t1_epc_frz",  trap_epc_o, 32'h200);
        ack_cycle();
        check("t1_ack_req",  {31'd0, trap_req_o}, 32'd0);
        check("t1_ack_mip",  {30'd0, mip_o}, 32'd0);
        mret_cycle();
        t_intr_i = 0;
        step(3);
        check("t1_idle", {31'd0, trap_req_o}, 32'd0);

        // 2: simultaneous sources, external first, then timer
        t_intr_i = 1; e_intr_i = 1;
        step(3);
        check("t2_mip", {30'd0, mip_o}, 32'd3);
        step(1);
        check("t2_req",   {31'd0, trap_req_o}, 32'd1);
        check("t2_cause", trap_cause_o, 32'h8000_000B);
        ack_cycle();
        check("t2_mip_ack", {30'd0, mip_o}, 32'd1);
        check("t2_handler", {31'd0, trap_req_o}, 32'd0);
        mret_cycle();
        step(1);
        check("t2_req2",   {31'd0, trap_req_o}, 32'd1);
        check("t2_cause2", trap_cause_o, 32'h8000_0007);
        ack_cycle();
        check("t2_mip_clr", {30'd0, mip_o}, 32'd0);
        mret_cycle();
        t_intr_i = 0; e_intr_i = 0;
        step(3);

        // 3: stall holds the request until the first unstalled edge
        stall_fd_i = 1;
        t_intr_i = 1;
        step(3);
        check("t3_mip", {30'd0, mip_o}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t3_stalled", {31'd0, trap_req_o}, 32'd0);
        end
        stall_fd_i = 0;
        step(1);
        check("t3_req", {31'd0, trap_req_o}, 32'd1);
        ack_cycle();
        mret_cycle();
        t_intr_i = 0;
        step(3);

        // 4: global enable gating, then losing enable while waiting
        mstatus_mie_i = 0;
        e_intr_i = 1;
        step(3);
        check("t4_mip", {30'd0, mip_o}, 32'd2);
        step(2);
        check("t4_noreq", {31'd0, trap_req_o}, 32'd0);
        mstatus_mie_i = 1;
        step(1);
        check("t4_req",   {31'd0, trap_req_o}, 32'd1);
        check("t4_cause", trap_cause_o, 32'h8000_000B);
        ack_cycle();
        mret_cycle();
        e_intr_i = 0;
        stall_fd_i = 1;
        t_intr_i = 1;
        step(4);
        check("t4_wait", {31'd0, trap_req_o}, 32'd0);
        mstatus_mie_i = 0;
        step(1);
        stall_fd_i = 0;
        step(2);
        check("t4_idle_req", {31'd0, trap_req_o}, 32'd0);
        check("t4_kept",     {30'd0, mip_o}, 32'd1);
        ack_cycle();
        check("t4_stray_ack", {30'd0, mip_o}, 32'd1);
        mstatus_mie_i = 1;
        step(1);
        check("t4_req2",   {31'd0, trap_req_o}, 32'd1);
        check("t4_cause2", trap_cause_o, 32'h8000_0007);
        ack_cycle();
        mret_cycle();
        t_intr_i = 0;
        step(3);

        // 5: no nesting in HANDLER; held-high line gives only one event
        t_intr_i = 1;
        step(4);
        check("t5_req", {31'd0, trap_req_o}, 32'd1);
        ack_cycle();
        e_intr_i = 1;
        step(3);
        check("t5_mip_h",  {30'd0, mip_o}, 32'd2);
        step(2);
        check("t5_nonest", {31'd0, trap_req_o}, 32'd0);
        mret_cycle();
        step(1);
        check("t5_req2",   {31'd0, trap_req_o}, 32'd1);
        check("t5_cause2", trap_cause_o, 32'h8000_000B);
        ack_cycle();
        mret_cycle();
        step(4);
        check("t5_held_req", {31'd0, trap_req_o}, 32'd0);
        check("t5_held_mip", {30'd0, mip_o}, 32'd0);
        t_intr_i = 0; e_intr_i = 0;
        step(3);

        // 6: asynchronous reset in TRAP
        t_intr_i = 1;
        pc_d_i = 32'h400;
        step(4);
        check("t6_req", {31'd0, trap_req_o}, 32'd1);
        rst_ni = 1'b0;
        t_intr_i = 0;
        #1;
        check("t6_rst_req",   {31'd0, trap_req_o}, 32'd0);
        check("t6_rst_flush", {31'd0, flush_o},    32'd0);
        check("t6_rst_mip",   {30'd0, mip_o},      32'd0);
        check("t6_rst_cause", trap_cause_o,        32'd0);
        check("t6_rst_epc",   trap_epc_o,          32'd0);
        step(2);
        rst_ni = 1'b1;
        step(5);
        check("t6_post_req", {31'd0, trap_req_o}, 32'd0);
        check("t6_post_mip", {30'd0, mip_o},      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
